// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run sequencer: FSM state encoding,
// the NOP instruction word and a helper that extracts a program entry address.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_LOAD,
        ST_RUN,
        ST_FINISH
    } run_state_t;

    localparam int INSTR_W = 9;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 9'b1_0000_0000;

    // Entry tables are zero-extended to this width so one helper serves any PC_W.
    localparam int BASE_BUS_W = 1024;

    function automatic logic [BASE_BUS_W-1:0] base_of(
        input logic [BASE_BUS_W-1:0] prog_base,
        input int                    slot,
        input int                    pc_w
    );
        return prog_base >> (slot * pc_w);
    endfunction

endpackage

// File: rtl/run_watchdog.sv
// RUN-cycle counter with synchronous clear; saturates at all-ones and flags
// the cycle on which the run must be forced to finish.
module run_watchdog
    import run_ctrl_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2**CNT_W) - 1) begin : g_bad_timeout
        $error("run_watchdog: TIMEOUT_CYCLES must be within 1..2**CNT_W-1");
    end

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && count_q != '1) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign expired = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/run_controller.sv
// Start/ack run sequencer: arms on start, launches on its falling edge, loads
// the selected entry point into the PC, gates the decoder and reports completion.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int                         PC_W           = 32,
    parameter int                         NUM_PROGS      = 4,
    parameter int                         SEL_W          = 2,
    parameter logic [NUM_PROGS*PC_W-1:0]  PROG_BASE      = '0,
    parameter int                         CNT_W          = 16,
    parameter int                         TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [SEL_W-1:0]   prog_sel,
    input  logic               done,
    input  logic [INSTR_W-1:0] fetch_instr,
    output logic [INSTR_W-1:0] dec_instr,
    output logic               run_en,
    output logic               pc_load,
    output logic [PC_W-1:0]    pc_load_addr,
    output logic               ack,
    output logic               timeout,
    output logic               bad_sel,
    output logic [CNT_W-1:0]   cycle_count
);

    localparam int IDX_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;

    if (SEL_W < IDX_W) begin : g_bad_sel_w
        $error("run_controller: SEL_W too narrow for NUM_PROGS");
    end
    if (NUM_PROGS * PC_W > BASE_BUS_W) begin : g_bad_base_w
        $error("run_controller: PROG_BASE wider than the entry bus");
    end

    localparam logic [BASE_BUS_W-1:0] BASE_BUS = BASE_BUS_W'(PROG_BASE);

    logic [PC_W-1:0] slot_base [NUM_PROGS];

    for (genvar gi = 0; gi < NUM_PROGS; gi++) begin : g_slot
        localparam logic [BASE_BUS_W-1:0] SHIFTED = base_of(BASE_BUS, gi, PC_W);
        assign slot_base[gi] = SHIFTED[PC_W-1:0];
    end

    run_state_t       state_q,   state_d;
    logic [SEL_W-1:0] sel_q,     sel_d;
    logic             ack_q,     ack_d;
    logic             timeout_q, timeout_d;
    logic             bad_sel_q, bad_sel_d;

    logic             sel_valid;
    logic [IDX_W-1:0] slot_idx;
    logic             wd_expired;

    assign sel_valid = int'(sel_q) < NUM_PROGS;
    assign slot_idx  = sel_valid ? sel_q[IDX_W-1:0] : '0;

    run_watchdog #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == ST_LOAD),
        .enable  (state_q == ST_RUN),
        .count   (cycle_count),
        .expired (wd_expired)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ack_d     = ack_q;
        timeout_d = timeout_q;
        bad_sel_d = bad_sel_q;
        case (state_q)
            ST_IDLE, ST_FINISH: begin
                if (start) begin
                    state_d   = ST_ARMED;
                    sel_d     = prog_sel;
                    ack_d     = 1'b0;
                    timeout_d = 1'b0;
                    bad_sel_d = 1'b0;
                end
            end
            ST_ARMED: begin
                if (start) begin
                    sel_d = prog_sel;
                end else begin
                    state_d   = ST_LOAD;
                    bad_sel_d = !sel_valid;
                end
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
                // done takes priority over a simultaneous watchdog expiry
                if (done) begin
                    state_d   = ST_FINISH;
                    ack_d     = 1'b1;
                    timeout_d = 1'b0;
                end else if (wd_expired) begin
                    state_d   = ST_FINISH;
                    ack_d     = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            bad_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ack_q     <= ack_d;
            timeout_q <= timeout_d;
            bad_sel_q <= bad_sel_d;
        end
    end

    assign run_en       = (state_q == ST_RUN);
    assign pc_load      = (state_q == ST_LOAD);
    assign pc_load_addr = slot_base[slot_idx];
    assign ack          = ack_q;
    assign timeout      = timeout_q;
    assign bad_sel      = bad_sel_q;
    assign dec_instr    = run_en ? fetch_instr : NOP_INSTR;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: 4 programs at {120,80,40,0}, 16-cycle
// watchdog, 8-bit counter, 3-bit program select.
module tb_run_controller;

    localparam logic [8:0] NOP = 9'b1_0000_0000;
    localparam logic [8:0] INS = 9'h0A5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  prog_sel = '0;
    logic        done = 1'b0;
    logic [8:0]  fetch_instr = INS;
    logic [8:0]  dec_instr;
    logic        run_en;
    logic        pc_load;
    logic [31:0] pc_load_addr;
    logic        ack;
    logic        timeout;
    logic        bad_sel;
    logic [7:0]  cycle_count;

    int tests_run = 0;
    int tests_failed = 0;
    int load_pulses = 0;

    run_controller #(
        .PC_W           (32),
        .NUM_PROGS      (4),
        .SEL_W          (3),
        .PROG_BASE      ({32'd120, 32'd80, 32'd40, 32'd0}),
        .CNT_W          (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .prog_sel     (prog_sel),
        .done         (done),
        .fetch_instr  (fetch_instr),
        .dec_instr    (dec_instr),
        .run_en       (run_en),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .ack          (ack),
        .timeout      (timeout),
        .bad_sel      (bad_sel),
        .cycle_count  (cycle_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pc_load === 1'b1) load_pulses++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // flags packed as {run_en, pc_load, ack, timeout, bad_sel}
    task automatic test_reset;
        logic [4:0] flags;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        flags = {run_en, pc_load, ack, timeout, bad_sel};
        tests_run++;
        if (flags !== 5'b00000) begin
            $display("FAIL reset_flags: got %b expected 00000", flags); tests_failed++;
        end
        tests_run++;
        if (cycle_count !== 8'd0 || pc_load_addr !== 32'd0) begin
            $display("FAIL reset_count_addr: got %0d/%0d expected 0/0", cycle_count, pc_load_addr); tests_failed++;
        end
        tests_run++;
        if (dec_instr !== NOP) begin
            $display("FAIL reset_nop: got %h expected %h", dec_instr, NOP); tests_failed++;
        end
        done = 1'b1; tick(); done = 1'b0;
        flags = {run_en, pc_load, ack, timeout, bad_sel};
        tests_run++;
        if (flags !== 5'b00000) begin
            $display("FAIL idle_done_ignored: got %b expected 00000", flags); tests_failed++;
        end
        $display("[TB] reset done");
    endtask

    task automatic test_basic_run;
        int p0;
        p0 = load_pulses;
        start = 1'b1; prog_sel = 3'd2;
        repeat (3) tick();
        start = 1'b0;
        tick();
        tests_run++;
        if ({run_en, pc_load} !== 2'b01 || pc_load_addr !== 32'd80 || dec_instr !== NOP) begin
            $display("FAIL basic_load: got run_en=%b pc_load=%b addr=%0d instr=%h expected 0/1/80/%h",
                     run_en, pc_load, pc_load_addr, dec_instr, NOP); tests_failed++;
        end
        tick();
        tests_run++;
        if ({run_en, pc_load} !== 2'b10 || cycle_count !== 8'd0 || dec_instr !== INS) begin
            $display("FAIL basic_run1: got run_en=%b pc_load=%b cnt=%0d instr=%h expected 1/0/0/%h",
                     run_en, pc_load, cycle_count, dec_instr, INS); tests_failed++;
        end
        repeat (4) tick();
        tests_run++;
        if (cycle_count !== 8'd4 || ack !== 1'b0) begin
            $display("FAIL basic_run5: got cnt=%0d ack=%b expected 4/0", cycle_count, ack); tests_failed++;
        end
        done = 1'b1; tick(); done = 1'b0;
        tests_run++;
        if ({ack, timeout, run_en} !== 3'b100 || cycle_count !== 8'd5) begin
            $display("FAIL basic_ack: got ack=%b to=%b run_en=%b cnt=%0d expected 1/0/0/5",
                     ack, timeout, run_en, cycle_count); tests_failed++;
        end
        tests_run++;
        if (load_pulses - p0 !== 1) begin
            $display("FAIL basic_pulses: got %0d expected 1", load_pulses - p0); tests_failed++;
        end
        tick(); done = 1'b1; tick(); done = 1'b0;
        tests_run++;
        if (ack !== 1'b1 || run_en !== 1'b0 || cycle_count !== 8'd5) begin
            $display("FAIL finish_hold: got ack=%b run_en=%b cnt=%0d expected 1/0/5", ack, run_en, cycle_count); tests_failed++;
        end
        $display("[TB] basic run sel=2 done");
    endtask

    task automatic test_timeout;
        start = 1'b1; prog_sel = 3'd0; tick();
        start = 1'b0; tick();
        tick();
        repeat (15) tick();
        tests_run++;
        if (cycle_count !== 8'd15 || ack !== 1'b0 || run_en !== 1'b1) begin
            $display("FAIL timeout_run16: got cnt=%0d ack=%b run_en=%b expected 15/0/1", cycle_count, ack, run_en); tests_failed++;
        end
        tick();
        tests_run++;
        if ({ack, timeout, run_en} !== 3'b110 || cycle_count !== 8'd16) begin
            $display("FAIL timeout_ack: got ack=%b to=%b run_en=%b cnt=%0d expected 1/1/0/16",
                     ack, timeout, run_en, cycle_count); tests_failed++;
        end
        repeat (3) tick();
        tests_run++;
        if ({ack, timeout, run_en} !== 3'b110 || cycle_count !== 8'd16) begin
            $display("FAIL timeout_hold: got ack=%b to=%b run_en=%b cnt=%0d expected 1/1/0/16",
                     ack, timeout, run_en, cycle_count); tests_failed++;
        end
        $display("[TB] timeout run done");
    endtask

    task automatic test_back_to_back;
        start = 1'b1; prog_sel = 3'd1; tick();
        tests_run++;
        if ({ack, timeout, run_en} !== 3'b000 || cycle_count !== 8'd16) begin
            $display("FAIL restart_clear: got ack=%b to=%b run_en=%b cnt=%0d expected 0/0/0/16",
                     ack, timeout, run_en, cycle_count); tests_failed++;
        end
        start = 1'b0; tick();
        tests_run++;
        if (pc_load !== 1'b1 || pc_load_addr !== 32'd40) begin
            $display("FAIL restart_load: got pc_load=%b addr=%0d expected 1/40", pc_load, pc_load_addr); tests_failed++;
        end
        tick();
        tests_run++;
        if (cycle_count !== 8'd0 || run_en !== 1'b1) begin
            $display("FAIL restart_count: got cnt=%0d run_en=%b expected 0/1", cycle_count, run_en); tests_failed++;
        end
        tick(); done = 1'b1; tick(); done = 1'b0;
        tests_run++;
        if ({ack, timeout} !== 2'b10 || cycle_count !== 8'd2) begin
            $display("FAIL restart_ack: got ack=%b to=%b cnt=%0d expected 1/0/2", ack, timeout, cycle_count); tests_failed++;
        end
        $display("[TB] back-to-back run sel=1 done");
    endtask

    task automatic test_done_at_timeout;
        start = 1'b1; prog_sel = 3'd3; tick();
        start = 1'b0; tick();
        tests_run++;
        if (pc_load_addr !== 32'd120 || bad_sel !== 1'b0) begin
            $display("FAIL slot3_addr: got addr=%0d bad_sel=%b expected 120/0", pc_load_addr, bad_sel); tests_failed++;
        end
        tick();
        repeat (15) tick();
        done = 1'b1; tick(); done = 1'b0;
        tests_run++;
        if ({ack, timeout, run_en} !== 3'b100 || cycle_count !== 8'd16) begin
            $display("FAIL done_wins: got ack=%b to=%b run_en=%b cnt=%0d expected 1/0/0/16",
                     ack, timeout, run_en, cycle_count); tests_failed++;
        end
        $display("[TB] done on timeout cycle done");
    endtask

    task automatic test_bad_sel;
        start = 1'b1; prog_sel = 3'd3; tick();
        tests_run++;
        if (bad_sel !== 1'b0 || ack !== 1'b0) begin
            $display("FAIL badsel_armed: got bad_sel=%b ack=%b expected 0/0", bad_sel, ack); tests_failed++;
        end
        prog_sel = 3'd5; tick();
        start = 1'b0; tick();
        tests_run++;
        if (pc_load !== 1'b1 || pc_load_addr !== 32'd0 || bad_sel !== 1'b1) begin
            $display("FAIL badsel_load: got pc_load=%b addr=%0d bad_sel=%b expected 1/0/1",
                     pc_load, pc_load_addr, bad_sel); tests_failed++;
        end
        tick(); done = 1'b1; tick(); done = 1'b0;
        tests_run++;
        if ({ack, timeout, bad_sel} !== 3'b101 || cycle_count !== 8'd1) begin
            $display("FAIL badsel_finish: got ack=%b to=%b bad_sel=%b cnt=%0d expected 1/0/1/1",
                     ack, timeout, bad_sel, cycle_count); tests_failed++;
        end
        $display("[TB] bad select run done");
    endtask

    task automatic test_abort;
        logic [4:0] flags;
        start = 1'b1; prog_sel = 3'd2; tick();
        start = 1'b0; tick();
        tick();
        tick();
        start = 1'b1; tick();
        tests_run++;
        if ({run_en, pc_load, ack} !== 3'b100 || cycle_count !== 8'd2) begin
            $display("FAIL start_in_run: got run_en=%b pc_load=%b ack=%b cnt=%0d expected 1/0/0/2",
                     run_en, pc_load, ack, cycle_count); tests_failed++;
        end
        tick(); start = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (run_en !== 1'b1 || cycle_count !== 8'd6 || pc_load_addr !== 32'd80) begin
            $display("FAIL abort_run7: got run_en=%b cnt=%0d addr=%0d expected 1/6/80",
                     run_en, cycle_count, pc_load_addr); tests_failed++;
        end
        reset = 1'b1; tick(); reset = 1'b0;
        flags = {run_en, pc_load, ack, timeout, bad_sel};
        tests_run++;
        if (flags !== 5'b00000 || cycle_count !== 8'd0 || pc_load_addr !== 32'd0) begin
            $display("FAIL abort_reset: got flags=%b cnt=%0d addr=%0d expected 00000/0/0",
                     flags, cycle_count, pc_load_addr); tests_failed++;
        end
        repeat (2) tick();
        flags = {run_en, pc_load, ack, timeout, bad_sel};
        tests_run++;
        if (flags !== 5'b00000) begin
            $display("FAIL abort_idle: got flags=%b expected 00000", flags); tests_failed++;
        end
        $display("[TB] mid-run reset done");
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_timeout();
        test_back_to_back();
        test_done_at_timeout();
        test_bad_sel();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
